// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared definitions for the data-memory arbiter.
//   ADDR_W  - word address width of both request ports and the memory
//   DATA_W  - data width of both request ports and the memory
//   owner_e - identifies which port owns a grant / pending read response
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arb_starve.sv
// dmem_arb_starve: DMA starvation counter for the data-memory arbiter.
// Counts consecutive cycles in which the DMA requests but is not granted and
// raises force_dma once that count reaches STARVE_MAX, so the DMA wins the
// next arbitration regardless of the CPU.
//   clk       - clock, rising edge
//   reset_n   - asynchronous active-low reset
//   dma_req   - DMA request (this cycle)
//   dma_gnt   - DMA grant (this cycle)
//   force_dma - DMA must be granted this cycle
module dmem_arb_starve
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    // Any gap in the DMA request or a DMA grant restarts the denial streak.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!dma_req || dma_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Depends only on the request and registered state, so the grant logic
    // that consumes it stays loop-free.
    assign force_dma = dma_req && (starve_cnt == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU, DMA) arbiter in front of a single-port data
// memory with registered read data (1-cycle read latency).
// The CPU wins ties unless the DMA has been denied STARVE_MAX cycles in a row.
//   clk, reset_n                 - clock / asynchronous active-low reset
//   cpu_req/wr/addr/wdata        - CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata - CPU grant and read response
//   dma_req/wr/addr/wdata        - DMA request, held until dma_gnt
//   dma_gnt, dma_rvalid, dma_rdata - DMA grant and read response
//   dmem_addr, dmem_data_in, dmem_wr - memory command
//   dmem_data_out                - memory read data, valid the cycle after the address
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_data_in,
    output logic              dmem_wr,
    input  logic [DATA_W-1:0] dmem_data_out
);

    logic              force_dma;
    logic              any_gnt;
    owner_e            winner;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic              tag_valid;
    owner_e            tag_owner;

    dmem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .reset_n   (reset_n),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt),
        .force_dma (force_dma)
    );

    // Grants are gated by reset_n so they drop immediately on reset assertion.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (reset_n) begin
            dma_gnt = dma_req && (force_dma || !cpu_req);
            cpu_gnt = cpu_req && !dma_gnt;
        end
    end

    always_comb begin
        any_gnt   = cpu_gnt || dma_gnt;
        winner    = dma_gnt ? OWN_DMA : OWN_CPU;
        win_wr    = (winner == OWN_DMA) ? dma_wr    : cpu_wr;
        win_addr  = (winner == OWN_DMA) ? dma_addr  : cpu_addr;
        win_wdata = (winner == OWN_DMA) ? dma_wdata : cpu_wdata;
    end

    // Without a grant the address holds its last granted value; write data
    // is forced to zero.
    always_comb begin
        dmem_addr    = any_gnt ? win_addr : addr_q;
        dmem_data_in = any_gnt ? win_wdata : '0;
        dmem_wr      = any_gnt && win_wr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            tag_valid <= 1'b0;
            tag_owner <= OWN_CPU;
        end else begin
            if (any_gnt) begin
                addr_q <= win_addr;
            end
            tag_valid <= any_gnt && !win_wr;
            tag_owner <= winner;
        end
    end

    assign cpu_rvalid = tag_valid && (tag_owner == OWN_CPU);
    assign dma_rvalid = tag_valid && (tag_owner == OWN_DMA);
    assign cpu_rdata  = dmem_data_out;
    assign dma_rdata  = dmem_data_out;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: the number of consecutive denied DMA request cycles that forces one DMA grant.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 cpu_req  input  1  CPU access request; held with its fields until granted.
REQ-005 cpu_wr  input  1  1 = write, 0 = read.
REQ-006 cpu_addr  input  16  CPU word address.
REQ-007 cpu_wdata  input  32  CPU write data.
REQ-008 cpu_gnt  output  1  CPU request accepted this cycle.
REQ-009 cpu_rvalid  output  1  CPU read data valid.
REQ-010 cpu_rdata  output  32  CPU read data.
REQ-011 dma_req, dma_wr, dma_addr[16], dma_wdata[32]  input  as CPU  DMA request port, same rules as REQ-004 to REQ-007.
REQ-012 dma_gnt, dma_rvalid, dma_rdata[32]  output  as CPU  DMA response port.
REQ-013 dmem_addr  output  16  memory address.
REQ-014 dmem_data_in  output  32  memory write data.
REQ-015 dmem_wr  output  1  memory write enable.
REQ-016 dmem_data_out  input  32  registered memory read data; valid one cycle after the address is presented.

Function
REQ-017 Grant decision is combinational within the cycle; a transfer occurs when req and gnt are both 1 at a rising edge.
REQ-018 At most one of cpu_gnt and dma_gnt is 1 in any cycle; gnt is never 1 without the matching req.
REQ-019 Default policy: the CPU wins when both ports request.
REQ-020 starve_cnt, width ceil(log2(STARVE_MAX+1)): +1 on each cycle where dma_req=1 and dma_gnt=0; cleared on a DMA grant or when dma_req=0.
REQ-021 When starve_cnt == STARVE_MAX and dma_req=1, the DMA wins regardless of cpu_req.
REQ-022 starve_cnt saturates at STARVE_MAX.
REQ-023 The winner's addr drives dmem_addr and its wdata drives dmem_data_in; dmem_wr = winner_wr & gnt.
REQ-024 With no grant: dmem_wr=0, dmem_addr holds its last granted value, and dmem_data_in=0.
REQ-025 Response tag register: {valid, owner} captured on each granted read; cleared on a granted write or an idle cycle.
REQ-026 Read latency is exactly 1 cycle: the owner's rvalid=1 in the cycle after the grant; the other port's rvalid=0.
REQ-027 Both cpu_rdata and dma_rdata are driven from dmem_data_out.
REQ-028 Back-to-back reads from alternating owners each return to the correct port with no bubble.
REQ-029 Read after write to the same address in consecutive cycles returns the new data. The memory's read-before-write is hidden because the read is issued a cycle later.
REQ-030 A request whose fields change while ungranted is undefined; no checking is required.

Reset
REQ-031 While reset_n=0: cpu_gnt=dma_gnt=0, dmem_wr=0, both rvalid=0, starve_cnt=0, tag valid=0, dmem_addr=0.
REQ-032 Reset asserted mid-read drops the pending response; no rvalid follows deassertion.
REQ-033 The first grant is possible in the first rising edge after reset_n rises.

Structure
REQ-034 A shared package holds the owner encoding (OWN_CPU=0, OWN_DMA=1), the address width 16 and the data width 32.
REQ-035 A single sub-module, dmem_arb_starve (the starvation counter plus force flag), is permitted; everything else stays flat.

Verification
REQ-036 CPU write addr 0x0010 data 0xDEADBEEF, then CPU read 0x0010 -> cpu_rvalid one cycle later with cpu_rdata=0xDEADBEEF, dma_rvalid=0.
REQ-037 Both ports request reads continuously, STARVE_MAX=4 -> grants are CPU x4 then DMA x1, repeating; each rvalid is routed to the correct port.
REQ-038 DMA write 0x0100 data 0x12345678 in cycle N, then CPU read 0x0100 in cycle N+1 -> cpu_rdata=0x12345678 in cycle N+2.
REQ-039 reset_n pulsed low while a CPU read is pending -> all outputs are 0 immediately; no cpu_rvalid after release.
REQ-040 dma_req is dropped after 3 denied cycles and then reasserted -> the counter restarts at 0, and the DMA is forced only after 4 further denials.
REQ-041 No requests for 10 cycles -> dmem_wr=0 and both rvalid=0 throughout.
